alu_seq_ctrl: RTL



---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_seq_ctrl_timeout_counter.sv | 34 +++
 rtl/alu_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: state encoding,
// ALU opcode constants and small helpers.
package alu_seq_pkg;

  // State encoding
  localparam logic [2:0] ST_A       = 3'd0;
  localparam logic [2:0] ST_B       = 3'd1;
  localparam logic [2:0] ST_OP      = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    S_A       = ST_A,
    S_B       = ST_B,
    S_OP      = ST_OP,
    S_EXEC    = ST_EXEC,
    S_WAIT_TX = ST_WAIT_TX
  } state_t;

  // ALU opcodes (low 6 bits of the opcode byte)
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  // The sequencer reports busy while an operation is executing or
  // its result is being transmitted.
  function automatic logic is_busy_state(input state_t s);
    return (s == S_EXEC) || (s == S_WAIT_TX);
  endfunction

  // Counter width able to hold values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, clears on request,
// and flags the cycle in which TERMINAL enabled cycles have elapsed.
module seq_timeout_counter
  import alu_seq_pkg::*;
#(
  parameter int unsigned TERMINAL = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tc
);

  localparam int unsigned CW = cnt_width(TERMINAL);
  localparam logic [CW-1:0] TC_VAL = CW'(TERMINAL - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles; clear has priority over counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Terminal count: the current edge is the TERMINAL-th enabled edge.
  assign o_tc = i_en && (r_count == TC_VAL);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer between the serial link and the ALU load unit.
// Collects operand A, operand B and opcode bytes, strobes each into the
// load unit, waits two cycles for the ALU to settle, then hands the
// result to the transmitter.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abandon a partial
// command after TIMEOUT_CYCLES idle cycles in S_B / S_OP.
// Handshake: i_rx_valid, i_tx_done and all output strobes are one-cycle
// pulses with no backpressure; a byte arriving while busy is dropped
// and reported on o_overrun.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MODE_WIDTH     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  o_load_A,
  output logic                  o_load_B,
  output logic                  o_load_op,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_timeout,
  output logic [2:0]            o_dbg_state
);

  if (MODE_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("alu_seq_ctrl: MODE_WIDTH must not exceed DATA_WIDTH and TIMEOUT_CYCLES must be nonzero");
  end

  state_t                r_state, w_state_nxt;
  logic                  r_settle, w_settle_nxt;
  logic [DATA_WIDTH-1:0] r_data_bus, w_bus_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic                  r_load_a, w_load_a_nxt;
  logic                  r_load_b, w_load_b_nxt;
  logic                  r_load_op, w_load_op_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic                  r_busy;
  logic                  w_tc;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic w_cnt_en;
  logic w_cnt_clear;

  // Count only while a command is partially received; any accepted byte
  // or a fired timeout restarts the count.
  assign w_cnt_en    = (r_state == S_B) || (r_state == S_OP);
  assign w_cnt_clear = !w_cnt_en || i_rx_valid || w_tc;

  seq_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_cnt_en),
    .i_clear (w_cnt_clear),
    .o_tc    (w_tc)
  );
`else
  assign w_tc = 1'b0;
`endif

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_settle_nxt   = r_settle;
    w_bus_nxt      = r_data_bus;
    w_tx_data_nxt  = r_tx_data;
    w_load_a_nxt   = 1'b0;
    w_load_b_nxt   = 1'b0;
    w_load_op_nxt  = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_overrun_nxt  = 1'b0;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      S_A: begin
        if (i_rx_valid) begin
          w_bus_nxt    = i_rx_data;
          w_load_a_nxt = 1'b1;
          w_state_nxt  = S_B;
        end
      end
      S_B, S_OP: begin
        if (w_tc) begin
          // Abandon the partial command; a byte on this edge starts a new one.
          w_timeout_nxt = 1'b1;
          if (i_rx_valid) begin
            w_bus_nxt    = i_rx_data;
            w_load_a_nxt = 1'b1;
            w_state_nxt  = S_B;
          end else begin
            w_state_nxt  = S_A;
          end
        end else if (i_rx_valid) begin
          w_bus_nxt = i_rx_data;
          if (r_state == S_B) begin
            w_load_b_nxt = 1'b1;
            w_state_nxt  = S_OP;
          end else begin
            w_load_op_nxt = 1'b1;
            w_settle_nxt  = 1'b0;
            w_state_nxt   = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        w_overrun_nxt = i_rx_valid;
        if (r_settle) begin
          w_tx_data_nxt  = i_alu_result;
          w_tx_start_nxt = 1'b1;
          w_settle_nxt   = 1'b0;
          w_state_nxt    = S_WAIT_TX;
        end else begin
          w_settle_nxt   = 1'b1;
        end
      end
      S_WAIT_TX: begin
        w_overrun_nxt = i_rx_valid;
        if (i_tx_done) begin
          w_state_nxt = S_A;
        end
      end
      default: begin
        w_state_nxt  = S_A;
        w_settle_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_A;
      r_settle   <= 1'b0;
      r_data_bus <= '0;
      r_tx_data  <= '0;
      r_load_a   <= 1'b0;
      r_load_b   <= 1'b0;
      r_load_op  <= 1'b0;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_settle   <= w_settle_nxt;
      r_data_bus <= w_bus_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_load_a   <= w_load_a_nxt;
      r_load_b   <= w_load_b_nxt;
      r_load_op  <= w_load_op_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_overrun  <= w_overrun_nxt;
      r_timeout  <= w_timeout_nxt;
      r_busy     <= is_busy_state(w_state_nxt);
    end
  end

  assign o_data_bus  = r_data_bus;
  assign o_load_A    = r_load_a;
  assign o_load_B    = r_load_b;
  assign o_load_op   = r_load_op;
  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_timeout   = r_timeout;
  assign o_dbg_state = r_state;

endmodule
